// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encoding,
// segment bit order and the hex glyph table.
package seg_pkg;

  typedef enum logic {
    S_GAP = 1'b0,
    S_ON  = 1'b1
  } scan_state_t;

  // Segment bit positions inside the 7-bit seg bus: {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1100111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b0111001;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_nibble_lut.sv
// Combinational hex nibble to seven-segment glyph lookup.
module seg_nibble_lut
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with blanking gaps and
// frame-atomic data update. Optional blink feature under SEG_BLINK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_BYTES    = 2,
  parameter int PRESCALE     = 50000,
`ifdef SEG_BLINK_EN
  parameter int BLINK_FRAMES = 64,
`endif
  parameter int GAP_CYCLES   = 500
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef SEG_BLINK_EN
  input  logic                     blink_en,
`endif
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [8*NUM_BYTES-1:0]   wr_data,
  input  logic                     blank,
  output logic [6:0]               seg,
  output logic [2*NUM_BYTES-1:0]   an_n,
  output logic                     frame_done
);

  localparam int D    = 2 * NUM_BYTES;
  localparam int DW   = $clog2(D);
  localparam int W    = 8 * NUM_BYTES;
  localparam int TMAX = max_int(PRESCALE, GAP_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  scan_state_t   state, state_next;
  logic [TW-1:0] tick, tick_next;
  logic [DW-1:0] dig_idx, dig_next;
  logic [W-1:0]  disp_reg, disp_next;
  logic [W-1:0]  pend_reg, pend_next;
  logic          pend_vld, pend_vld_next;
  logic          wrap;
  logic          dark;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [6:0]    seg_next;
  logic [D-1:0]  an_next;

  // Valid/ready: a transfer happens on any rising edge where wr_valid and
  // wr_ready are both high. wr_ready is purely a function of registered
  // state (!pend_vld), so it never depends on wr_valid in the same cycle.
  assign wr_ready = !pend_vld;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_GAP;
      tick     <= '0;
      dig_idx  <= '0;
      disp_reg <= '0;
      pend_reg <= '0;
      pend_vld <= 1'b0;
    end else begin
      state    <= state_next;
      tick     <= tick_next;
      dig_idx  <= dig_next;
      disp_reg <= disp_next;
      pend_reg <= pend_next;
      pend_vld <= pend_vld_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state;
    tick_next  = tick + TW'(1);
    dig_next   = dig_idx;
    wrap       = 1'b0;
    case (state)
      S_GAP: begin
        if (GAP_CYCLES == 0 || tick == TW'(GAP_CYCLES - 1)) begin
          state_next = S_ON;
          tick_next  = '0;
        end
      end
      S_ON: begin
        if (tick == TW'(PRESCALE - 1)) begin
          tick_next  = '0;
          state_next = (GAP_CYCLES == 0) ? S_ON : S_GAP;
          if (dig_idx == DW'(D - 1)) begin
            dig_next = '0;
            wrap     = 1'b1;
          end else begin
            dig_next = dig_idx + DW'(1);
          end
        end
      end
      default: begin
        state_next = S_GAP;
        tick_next  = '0;
      end
    endcase
  end

  // The swap looks at pend_vld before this edge, so a write landing on the
  // wrap edge is held until the following wrap.
  always_comb begin
    disp_next     = disp_reg;
    pend_next     = pend_reg;
    pend_vld_next = pend_vld;
    if (wrap && pend_vld) begin
      disp_next     = pend_reg;
      pend_vld_next = 1'b0;
    end else if (wr_valid && wr_ready) begin
      pend_next     = wr_data;
      pend_vld_next = 1'b1;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FCW = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;

  logic [FCW-1:0] frame_cnt, frame_cnt_next;

  always_comb begin
    frame_cnt_next = frame_cnt;
    if (wrap) begin
      if (frame_cnt == FCW'(2 * BLINK_FRAMES - 1)) frame_cnt_next = '0;
      else                                         frame_cnt_next = frame_cnt + FCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else        frame_cnt <= frame_cnt_next;
  end

  // Uses the post-edge count so the dark phase starts exactly on a frame boundary.
  assign dark = blank || (blink_en && (frame_cnt_next >= FCW'(BLINK_FRAMES)));
`else
  assign dark = blank;
`endif

  // ---------------- output logic ----------------
  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  assign nibble = disp_next[{dig_next, 2'b00} +: 4];

  seg_nibble_lut u_lut (
    .nibble (nibble),
    .glyph  (glyph)
  );

  always_comb begin
    seg_next = SEG_OFF;
    an_next  = '1;
    if (state_next == S_ON && !dark) begin
      seg_next          = glyph;
      an_next[dig_next] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      an_n       <= an_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (NUM_BYTES=2, PRESCALE=4,
// GAP_CYCLES=1, frame = 20 cycles). Blink scenario runs when SEG_BLINK_EN is set.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  an_n;
  logic        frame_done;
`ifdef SEG_BLINK_EN
  logic        blink_en;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [6:0] exp_q[$];

  seg_scan_ctrl #(
    .NUM_BYTES    (2),
    .PRESCALE     (4),
`ifdef SEG_BLINK_EN
    .BLINK_FRAMES (2),
`endif
    .GAP_CYCLES   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SEG_BLINK_EN
    .blink_en   (blink_en),
`endif
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .blank      (blank),
    .seg        (seg),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0:  return 7'b0111111;
      1:  return 7'b0000110;
      2:  return 7'b1011011;
      3:  return 7'b1001111;
      4:  return 7'b1100110;
      5:  return 7'b1101101;
      6:  return 7'b1111101;
      7:  return 7'b0000111;
      8:  return 7'b1111111;
      9:  return 7'b1100111;
      10: return 7'b1110111;
      11: return 7'b1111100;
      12: return 7'b0111001;
      13: return 7'b1011110;
      14: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // cyc = number of rising edges since reset release; sampled at negedge.
  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    blank    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Digit d of the frame starting at cycle s is lit in cycles s+1+5d .. s+4+5d.
  task automatic check_frame(input int s, input int first, input int last);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    for (int d = first; d <= last; d++) begin
      goto(s + 1 + 5 * d);
      e_an    = 4'b1111;
      e_an[d] = 1'b0;
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 16'd1, 16'd0);
        e_seg = 7'b0;
      end else begin
        e_seg = exp_q.pop_front();
      end
      check($sformatf("an_d%0d", d), 16'(an_n), 16'(e_an));
      check($sformatf("seg_d%0d", d), 16'(seg), 16'(e_seg));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
`ifdef SEG_BLINK_EN
    blink_en = 1'b0;
`endif
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    blank    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", 16'(an_n), 16'hF);
    check("rst_seg", 16'(seg), 16'h0);
    check("rst_ready", 16'(wr_ready), 16'h1);
    check("rst_fd", 16'(frame_done), 16'h0);
    rst_n = 1'b1;
    cyc   = 0;
    check("gap0_an", 16'(an_n), 16'hF);

    // Frame 0: digit 0 lit, then write 12AF during digit 0
    goto(1);
    check("f0_an0", 16'(an_n), 16'hE);
    check("f0_seg0", 16'(seg), 16'(glyph(0)));
    wr_valid = 1'b1;
    wr_data  = 16'h12AF;
    goto(2);
    wr_valid = 1'b0;
    check("wr1_ready_low", 16'(wr_ready), 16'h0);
    goto(4);
    check("f0_an0_end", 16'(an_n), 16'hE);
    goto(5);
    check("f0_gap1", 16'(an_n), 16'hF);
    for (int i = 0; i < 3; i++) exp_q.push_back(glyph(0));
    check_frame(0, 1, 3);
    goto(19);
    check("f0_ready_low", 16'(wr_ready), 16'h0);
    check("f0_fd_low", 16'(frame_done), 16'h0);

    // Frame 1: shows 12AF; write A accepted, then B held while not ready
    goto(20);
    check("f1_fd", 16'(frame_done), 16'h1);
    check("f1_ready", 16'(wr_ready), 16'h1);
    check("f1_gap_an", 16'(an_n), 16'hF);
    exp_q.push_back(glyph(15));
    exp_q.push_back(glyph(10));
    exp_q.push_back(glyph(2));
    exp_q.push_back(glyph(1));
    check_frame(20, 0, 0);
    check("f1_fd_pulse", 16'(frame_done), 16'h0);
    check("f1_ready_hold", 16'(wr_ready), 16'h1);
    goto(22);
    wr_valid = 1'b1;
    wr_data  = 16'h3C5E;
    goto(23);
    check("wrA_ready_low", 16'(wr_ready), 16'h0);
    wr_data = 16'h0987;
    check_frame(20, 1, 3);
    goto(39);
    check("f1_ready_low", 16'(wr_ready), 16'h0);

    // Frame 2: A shown, B accepted right after the wrap
    goto(40);
    check("f2_fd", 16'(frame_done), 16'h1);
    check("f2_ready", 16'(wr_ready), 16'h1);
    goto(41);
    check("wrB_ready_low", 16'(wr_ready), 16'h0);
    wr_valid = 1'b0;
    exp_q.push_back(glyph(14));
    exp_q.push_back(glyph(5));
    exp_q.push_back(glyph(12));
    exp_q.push_back(glyph(3));
    check_frame(40, 0, 3);

    // Frame 3: B shown
    exp_q.push_back(glyph(7));
    exp_q.push_back(glyph(8));
    exp_q.push_back(glyph(9));
    exp_q.push_back(glyph(0));
    check_frame(60, 0, 3);

    // Frame 4: blank during digit 2, resume in phase
    exp_q.push_back(glyph(7));
    exp_q.push_back(glyph(8));
    check_frame(80, 0, 1);
    goto(91);
    check("blk_pre_an", 16'(an_n), 16'hB);
    blank = 1'b1;
    goto(92);
    check("blk_an", 16'(an_n), 16'hF);
    check("blk_seg", 16'(seg), 16'h0);
    goto(96);
    check("blk_d3_an", 16'(an_n), 16'hF);
    blank = 1'b0;
    goto(97);
    check("unblk_an", 16'(an_n), 16'h7);
    check("unblk_seg", 16'(seg), 16'(glyph(0)));
    goto(100);
    check("blk_fd_phase", 16'(frame_done), 16'h1);

    // Frame 5: pending write, then reset during digit 2
    goto(101);
    check("f5_an0", 16'(an_n), 16'hE);
    wr_valid = 1'b1;
    wr_data  = 16'hFFFF;
    goto(102);
    wr_valid = 1'b0;
    check("wrC_ready_low", 16'(wr_ready), 16'h0);
    goto(112);
    check("f5_an2", 16'(an_n), 16'hB);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 16'(an_n), 16'hF);
    check("mid_rst_seg", 16'(seg), 16'h0);
    check("mid_rst_ready", 16'(wr_ready), 16'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(glyph(0));
    check_frame(0, 0, 3);
    goto(20);
    check("post_rst_fd", 16'(frame_done), 16'h1);
    check_frame(20, 0, 3);

`ifdef SEG_BLINK_EN
    blink_en = 1'b1;
    do_reset();
    goto(1);
    check("blink_f0", 16'(an_n), 16'hE);
    goto(21);
    check("blink_f1", 16'(an_n), 16'hE);
    goto(41);
    check("blink_f2", 16'(an_n), 16'hF);
    goto(61);
    check("blink_f3", 16'(an_n), 16'hF);
    goto(81);
    check("blink_f4", 16'(an_n), 16'hE);
    blink_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's seven-segment display bank. It holds NUM_BYTES bytes (2·NUM_BYTES hex digits) and drives one digit at a time through shared segment lines. A blanking gap between digits suppresses ghosting. New display data is accepted through a valid/ready handshake and swapped in atomically at a frame boundary, so a partially updated value is never shown.

## Interface
- NUM_BYTES, 2, bytes displayed; digit count D = 2·NUM_BYTES.
- PRESCALE, 50000, clk cycles each digit is lit (≥1).
- GAP_CYCLES, 500, clk cycles with all digits off between digits (0 = no gap).
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  new display data offered.
- wr_ready  out  1  controller can accept data.
- wr_data  in  8·NUM_BYTES  digit i shows nibble wr_data[4i+3:4i].
- blank  in  1  forces the display dark; scanning continues.
- seg  out  7  {g,f,e,d,c,b,a}, active-high.
- an_n  out  D  digit enables, active-low, one-hot-cold.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit D-1 to digit 0.

## Operation
- Registers:
  - disp_reg: shown data.
  - pend_reg plus pend_vld.
  - dig_idx: 0..D-1.
  - tick counter.
  - state.
- FSM states:
  - S_GAP: an_n all ones, seg=0. Stays for GAP_CYCLES cycles, then goes to S_ON. If GAP_CYCLES=0, S_GAP is skipped.
  - S_ON: an_n[dig_idx]=0, seg=glyph(disp_reg nibble dig_idx). Stays for PRESCALE cycles, then dig_idx increments and the FSM goes to S_GAP.
- Wrap: when dig_idx=D-1 leaves S_ON:
  - dig_idx←0 and frame_done pulses.
  - If pend_vld: disp_reg←pend_reg and pend_vld←0.
- Handshake:
  - wr_ready = !pend_vld (registered state, no combinational path from wr_valid).
  - Transfer happens when wr_valid && wr_ready: pend_reg←wr_data, pend_vld←1.
  - The wrap decision uses pend_vld as it is before the edge. A write accepted on the wrap edge therefore waits for the next wrap.
- blank=1: seg=0 and an_n all ones from the next cycle. The FSM, counters and handshake are unaffected.
- Glyphs for 0-F: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1100111, 1110111, 1111100, 0111001, 1011110, 1111001, 1110001.

## Timing
- Reset values:
  - Outputs: seg=0, an_n=all ones, wr_ready=1, frame_done=0.
  - Internal: disp_reg=0, pend_vld=0, dig_idx=0, tick=0, state=S_GAP.
- seg, an_n and frame_done are registered and change on the edge where the state changes.
- Frame length F = D·(PRESCALE+GAP_CYCLES) cycles.
- Write-to-display latency is at most 2F cycles and at least 1 cycle after the wrap.
- While pend_vld=1, wr_ready stays low. It returns high the cycle after the wrap.
- rst_n asserted mid-frame: all registers take their reset values immediately and pending data is discarded.
- The tick counter width is the clog2 of max(PRESCALE, GAP_CYCLES). It never overflows; it reloads at every state change.

## Configuration
- SEG_BLINK_EN defined:
  - Adds input port blink_en (1 bit) and parameter BLINK_FRAMES (default 64).
  - A frame counter increments on each frame_done and wraps at 2·BLINK_FRAMES.
  - When blink_en=1 and the counter is ≥ BLINK_FRAMES, the display is dark exactly as with blank.
  - The counter resets to 0 on rst_n.
- SEG_BLINK_EN undefined: no port, no counter; behaviour is as described above.

## Structure
- Package seg_pkg holds:
  - FSM state encoding (S_GAP, S_ON).
  - The 16 glyph constants.
  - The segment bit-order definition.
- One sub-module, seg_nibble_lut: combinational 4-bit → 7-bit glyph lookup. It is instanced once on the nibble selected by dig_idx.

## Test plan
All scenarios use NUM_BYTES=2, PRESCALE=4, GAP_CYCLES=1, so F=20.
- Reset, then release:
  - During reset: an_n=1111, seg=0, wr_ready=1.
  - After release: 1 gap cycle, then an_n=1110 with seg=0111111 for 4 cycles.
- Write 16'h12AF during digit 0:
  - wr_ready=0 next cycle and 0000 shown for the rest of the frame.
  - Next frame: digit0=1110001, digit1=1110111, digit2=1011011, digit3=0000110.
  - wr_ready=1 the cycle after frame_done.
- Second write held with wr_valid=1 while wr_ready=0:
  - Accepted after the wrap.
  - Shown one full frame later.
- blank=1 during digit 2:
  - an_n=1111 next cycle.
  - On release, the display resumes at whatever digit the counters have reached; no phase slip.
- rst_n low during digit 2 with pend_vld=1:
  - Outputs go to reset values immediately.
  - After release the display shows 0000.
- SEG_BLINK_EN with BLINK_FRAMES=2 and blink_en=1:
  - Frames 0-1 lit, frames 2-3 dark, frame 4 lit.
